// File: rtl/instr_loader_pkg.sv
// Shared constants and state encoding for the instruction loader and its datapath.
// The address width here must match the datapath's PC width.
package instr_loader_pkg;

    localparam int ADDR_W  = 8;
    localparam int DEPTH   = 256;
    localparam int DATA_W  = 8;
    localparam int COUNT_W = 9;

    localparam logic [DATA_W-1:0] NOP_WORD_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // True when a fetch address falls inside the currently loaded program.
    function automatic logic addr_loaded(input logic [ADDR_W-1:0] addr,
                                         input logic [COUNT_W-1:0] count);
        return ({1'b0, addr} < count);
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-wide valid/ready program load port between the board-level program source
// (master) and the instruction loader (slave).
interface instr_loader_if;
    import instr_loader_pkg::*;

    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;

    modport master (
        output load_start,
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_start,
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );

endinterface

// File: rtl/instr_loader_ram.sv
// 256x8 instruction store: synchronous write, asynchronous read so the datapath
// sees the word for PC in the same cycle. Contents are deliberately not reset.
module instr_ram
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_loader.sv
// Instruction-side responder: loads a program over the byte-wide load port, holds the
// datapath in reset while loading, then serves instructions combinationally for PC.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter logic [DATA_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic               CLK,
    input  logic               RESET,
    instr_loader_if.slave      load_if,
    input  logic [ADDR_W-1:0]  PC,
    output logic [DATA_W-1:0]  instruction,
    output logic               cpu_reset,
    output logic [COUNT_W-1:0] load_count
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               wr_en;
    logic               ready;
    logic [DATA_W-1:0]  ram_rdata;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // The 256th byte ends the load even without load_last, so ptr never wraps onto a write.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        wr_en     = 1'b0;
        ready     = 1'b0;
        cpu_reset = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (load_if.load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end

            ST_LOAD: begin
                ready = 1'b1;
                if (load_if.load_valid) begin
                    wr_en   = 1'b1;
                    ptr_d   = ptr_q + 8'd1;
                    count_d = count_q + 9'd1;
                    if (load_if.load_last || (count_q == 9'(DEPTH - 1))) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                cpu_reset = 1'b0;
                if (load_if.load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    instr_ram u_ram (
        .clk   (CLK),
        .we    (wr_en),
        .waddr (ptr_q),
        .wdata (load_if.load_data),
        .raddr (PC),
        .rdata (ram_rdata)
    );

    // Stale words beyond the current load are masked by the count gate.
    always_comb begin
        instruction = NOP_WORD;
        if ((state_q == ST_RUN) && addr_loaded(PC, count_q)) begin
            instruction = ram_rdata;
        end
    end

    assign load_if.load_ready = ready;
    assign load_count         = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table vectors, corner-case sequences and
// randomized loads compared against a behavioural program-store model.
module tb_instr_loader;
    import instr_loader_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] PC;
    logic [7:0] instruction;
    logic       cpu_reset;
    logic [8:0] load_count;

    instr_loader_if lif();

    instr_loader #(.NOP_WORD(8'h00)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .load_if     (lif),
        .PC          (PC),
        .instruction (instruction),
        .cpu_reset   (cpu_reset),
        .load_count  (load_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: what was loaded, how much, and whether the CPU may run.
    logic [7:0] model_mem [256];
    int         model_count   = 0;
    bit         model_loading = 0;
    bit         model_running = 0;

    typedef struct packed {
        logic       start;
        logic       valid;
        logic       last;
        logic [7:0] data;
        logic [7:0] pc;
        logic       exp_ready;
        logic       exp_cpu_reset;
        logic [8:0] exp_count;
        logic [7:0] exp_instr;
    } vec_t;

    vec_t vecs [10];

    task automatic applyStimulus(input logic start, input logic valid, input logic last,
                                 input logic [7:0] data);
        lif.load_start = start;
        lif.load_valid = valid;
        lif.load_last  = last;
        lif.load_data  = data;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] expInstr(input int pc);
        if (model_running && (pc < model_count)) return model_mem[pc];
        return 8'h00;
    endfunction

    task automatic modelEdge();
        if (model_loading) begin
            if (lif.load_valid) begin
                model_mem[model_count] = lif.load_data;
                model_count++;
                if (lif.load_last || model_count == 256) begin
                    model_loading = 0;
                    model_running = 1;
                end
            end
        end else if (lif.load_start) begin
            model_loading = 1;
            model_running = 0;
            model_count   = 0;
        end
    endtask

    task automatic cycle();
        modelEdge();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " load_ready"}, 16'(lif.load_ready), 16'(model_loading));
        checkOutput({tag, " cpu_reset"}, 16'(cpu_reset), 16'(!model_running));
        checkOutput({tag, " load_count"}, 16'(load_count), 16'(model_count));
        checkOutput({tag, " instruction"}, 16'(instruction), 16'(expInstr(int'(PC))));
    endtask

    task automatic sendProgram(input logic [7:0] prog[$], input bit gaps, input bit use_last,
                               input string tag);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        #1 checkModel({tag, " start"});
        cycle();
        for (int i = 0; i < prog.size(); i++) begin
            if (gaps) begin
                applyStimulus(1'b0, 1'b0, 1'b1, 8'hEE);
                #1 checkModel({tag, " gap"});
                cycle();
            end
            applyStimulus(1'b0, 1'b1, use_last && (i == prog.size() - 1), prog[i]);
            #1 checkModel({tag, " byte"});
            cycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic checkFetch(input string name, input logic [7:0] pc, input logic [7:0] exp);
        PC = pc;
        #1 checkOutput(name, 16'(instruction), 16'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] prog[$];
        int         len;
        int         budget;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 9'd0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 1'b1, 9'd0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 8'h22, 8'h00, 1'b1, 1'b1, 9'd1, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 8'h33, 8'h01, 1'b1, 1'b1, 9'd2, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 9'd3, 8'h11};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 9'd3, 8'h22};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 9'd3, 8'h33};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0, 9'd3, 8'h00};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 8'h99, 8'h02, 1'b0, 1'b0, 9'd3, 8'h33};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0, 9'd3, 8'h00};

        RESET = 1'b1;
        PC    = 8'h00;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;

        foreach (vecs[i]) begin
            PC = 8'h00;
            #1 checkOutput("idle instr", 16'(instruction), 16'h00);
            PC = 8'hFF;
            #1 checkOutput("idle instr ff", 16'(instruction), 16'h00);
            break;
        end

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].start, vecs[i].valid, vecs[i].last, vecs[i].data);
            PC = vecs[i].pc;
            #1;
            checkOutput($sformatf("vec%0d load_ready", i), 16'(lif.load_ready), 16'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d cpu_reset", i), 16'(cpu_reset), 16'(vecs[i].exp_cpu_reset));
            checkOutput($sformatf("vec%0d load_count", i), 16'(load_count), 16'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d instruction", i), 16'(instruction), 16'(vecs[i].exp_instr));
            cycle();
        end

        // Gapped load: valid every other cycle.
        prog = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        PC = 8'h00;
        sendProgram(prog, 1'b1, 1'b1, "gaps");
        #1 checkOutput("gaps count", 16'(load_count), 16'd4);
        checkFetch("gaps pc0", 8'h00, 8'hA1);
        checkFetch("gaps pc1", 8'h01, 8'hB2);
        checkFetch("gaps pc2", 8'h02, 8'hC3);
        checkFetch("gaps pc3", 8'h03, 8'hD4);
        checkFetch("gaps pc4", 8'h04, 8'h00);
        cycle();

        // Full 256-byte load without load_last.
        prog.delete();
        for (int i = 0; i < 256; i++) prog.push_back(8'(i));
        PC = 8'h10;
        sendProgram(prog, 1'b0, 1'b0, "full");
        #1 checkOutput("full count", 16'(load_count), 16'd256);
        checkOutput("full cpu_reset", 16'(cpu_reset), 16'd0);
        checkFetch("full pcff", 8'hFF, 8'hFF);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h77);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        #1 checkOutput("full 257th count", 16'(load_count), 16'd256);
        checkFetch("full 257th pc0", 8'h00, 8'h00);
        checkOutput("full 257th ready", 16'(lif.load_ready), 16'd0);

        // Reset in the middle of a 5-byte load.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        cycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h01);
        cycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h02);
        cycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h03);
        RESET = 1'b1;
        model_loading = 0;
        model_running = 0;
        model_count   = 0;
        #1;
        checkOutput("rst count", 16'(load_count), 16'd0);
        checkOutput("rst cpu_reset", 16'(cpu_reset), 16'd1);
        checkOutput("rst ready", 16'(lif.load_ready), 16'd0);
        @(posedge CLK);
        #1 RESET = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        prog = '{8'hA5};
        sendProgram(prog, 1'b0, 1'b1, "after rst");
        checkFetch("after rst pc0", 8'h00, 8'hA5);
        checkFetch("after rst pc1", 8'h01, 8'h00);
        cycle();

        // Reload while running.
        prog = '{8'h11, 8'h22, 8'h33};
        sendProgram(prog, 1'b0, 1'b1, "resident");
        checkFetch("resident pc1", 8'h01, 8'h22);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        #1 checkOutput("reload same-cycle cpu_reset", 16'(cpu_reset), 16'd0);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        #1 checkOutput("reload cpu_reset", 16'(cpu_reset), 16'd1);
        checkOutput("reload ready", 16'(lif.load_ready), 16'd1);
        checkOutput("reload count", 16'(load_count), 16'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A);
        cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkFetch("reload pc0", 8'h00, 8'h5A);
        checkFetch("reload pc1", 8'h01, 8'h00);
        checkFetch("reload pc2", 8'h02, 8'h00);
        cycle();

        // Randomized loads with gaps, spurious starts and run-time noise.
        for (int r = 0; r < 30; r++) begin
            len = $urandom_range(1, 24);
            applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom));
            PC = 8'($urandom_range(0, 31));
            #1 checkModel("rnd start");
            cycle();
            budget = 0;
            while (model_loading && budget < 400) begin
                logic v;
                v = ($urandom_range(0, 9) < 7);
                applyStimulus(1'($urandom_range(0, 3) == 0), v,
                              v ? (model_count == len - 1) : 1'($urandom), 8'($urandom));
                PC = 8'($urandom_range(0, 31));
                #1 checkModel("rnd load");
                cycle();
                budget++;
            end
            if (model_loading) begin
                checkOutput("rnd load budget", 16'd1, 16'd0);
            end
            for (int k = 0; k < 4; k++) begin
                applyStimulus(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
                PC = (k == 3) ? 8'($urandom) : 8'($urandom_range(0, 31));
                #1 checkModel("rnd run");
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
